truth_table_checker: RTL
========================

Name: truth_table_checker

Overview:
- Synthesizable self-checking stimulus/response engine for small combinational blocks such as the two-input Boolean expression units.
- On `start`, drives every input combination 0..2^N_IN-1 onto the DUT and waits a fixed settle time. It then samples the DUT output and compares it against a golden truth table given as a parameter.
- Reports mismatch count, first failing vector and pass/done.
- Sits beside the DUT in an on-board test wrapper, replacing a hand-written stimulus bench.

Parameters:
- N_IN, 2, number of DUT inputs (1..6)
- EXPECTED, 4'b1000, golden truth table, width 2^N_IN; bit i = expected DUT output when input vector = i (default = AND)
- SETTLE, 2, cycles dut_in is held before sampling (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a run; sampled only in IDLE or DONE
- dut_in  output  N_IN  stimulus vector to DUT (bit 0 = LSB input)
- dut_out  input  1  DUT response
- busy  output  1  high while a run is in progress
- done  output  1  high once a run completes; held until next start or reset
- pass  output  1  valid when done=1; 1 iff err_count==0
- err_count  output  N_IN+1  number of mismatching vectors
- first_fail_valid  output  1  a mismatch has been recorded this run
- first_fail_idx  output  N_IN  vector index of first mismatch

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0 (dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_idx=0); internal idx and settle counter = 0. Reset mid-run aborts immediately, with no partial results retained.
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE: start=1 at edge -> DRIVE with idx=0, dut_in=0, settle_cnt=0, busy=1, err_count=0, first_fail_valid=0, first_fail_idx=0.
- DRIVE:
  - dut_in=idx, held stable.
  - settle_cnt increments each cycle.
  - When settle_cnt==SETTLE-1, go to CHECK next edge, so DRIVE lasts exactly SETTLE cycles.
- CHECK (1 cycle): at the exiting edge, compare dut_out with EXPECTED[idx].
  - On mismatch: err_count += 1. If first_fail_valid==0, set first_fail_idx=idx and first_fail_valid=1.
  - If idx==2^N_IN-1: go to DONE, busy=0, done=1, pass=(final err_count==0), including the mismatch from this same cycle.
  - Otherwise: idx+1, settle_cnt=0, go to DRIVE.
- Per-vector cost: SETTLE+1 cycles. done rises exactly 2^N_IN*(SETTLE+1) cycles after the edge that accepted start.
- dut_in changes only on the CHECK->DRIVE edge (or the IDLE/DONE->DRIVE edge). It holds the last vector (2^N_IN-1) in DONE and is 0 in IDLE.
- start while busy (DRIVE/CHECK) is ignored and has no effect on counters.
- DONE: outputs frozen. start=1 restarts exactly as from IDLE: done=0, pass=0 and counters cleared on the same edge.
- err_count is N_IN+1 bits, so it can hold all 2^N_IN mismatches without wrap.
- Wrap of idx cannot occur because the terminal compare precedes the increment.
- dut_out is sampled only in CHECK; glitches during DRIVE are irrelevant.

Test Plan:
1. Golden AND DUT, defaults (N_IN=2, EXPECTED=4'b1000, SETTLE=2), pulse start -> dut_in steps 0,1,2,3 each held 3 cycles; done=1 exactly 12 cycles after start accepted; pass=1, err_count=0, first_fail_valid=0.
2. OR DUT against AND table -> mismatches at idx 1 and 2; err_count=2, first_fail_idx=1, first_fail_valid=1, pass=0.
3. dut_out stuck at 1 -> err_count=3, first_fail_idx=0, pass=0; stuck at 0 -> err_count=1, first_fail_idx=3.
4. Assert rst_n=0 during DRIVE of idx 2 (asynchronously, mid-cycle) -> all outputs 0 immediately; after release, start re-runs from idx 0 with a clean result.
5. start pulsed during DRIVE -> ignored, timing unchanged; start pulsed in DONE -> done and counters clear on the same edge, and a new run completes identically.
6. N_IN=3, EXPECTED=8'b1001_0110 (XOR3), SETTLE=1, XOR3 DUT -> 8 vectors, done after 16 cycles, pass=1; flip EXPECTED bit 7 -> err_count=1, first_fail_idx=7, pass=0.

Source files
------------

// File: rtl/truth_table_checker.sv
// Self-checking stimulus/response engine: walks every input vector of a small
// combinational DUT, lets it settle, and compares its output with a golden truth table.
module truth_table_checker #(
  parameter int                    N_IN     = 2,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED = 4'b1000,
  parameter int                    SETTLE   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [SW-1:0]   CNT_ONE     = SW'(1);
  localparam logic [N_IN-1:0] IDX_LAST    = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] IDX_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE     = (N_IN+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [N_IN-1:0]   idx, idx_nxt;
  logic [SW-1:0]     settle_cnt, settle_cnt_nxt;
  logic [N_IN:0]     err_nxt;
  logic              ffv_nxt;
  logic [N_IN-1:0]   ffi_nxt;
  logic              pass_nxt;
  logic              mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      idx              <= '0;
      settle_cnt       <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      pass             <= 1'b0;
    end else begin
      state            <= state_nxt;
      idx              <= idx_nxt;
      settle_cnt       <= settle_cnt_nxt;
      err_count        <= err_nxt;
      first_fail_valid <= ffv_nxt;
      first_fail_idx   <= ffi_nxt;
      pass             <= pass_nxt;
    end
  end

  assign mismatch = (dut_out != EXPECTED[idx]);

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    settle_cnt_nxt = settle_cnt;
    err_nxt        = err_count;
    ffv_nxt        = first_fail_valid;
    ffi_nxt        = first_fail_idx;
    pass_nxt       = pass;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt      = S_DRIVE;
          idx_nxt        = '0;
          settle_cnt_nxt = '0;
          err_nxt        = '0;
          ffv_nxt        = 1'b0;
          ffi_nxt        = '0;
          pass_nxt       = 1'b0;
        end
      end
      S_DRIVE: begin
        settle_cnt_nxt = settle_cnt + CNT_ONE;
        if (settle_cnt == SETTLE_LAST) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (mismatch) begin
          err_nxt = err_count + ERR_ONE;
          if (!first_fail_valid) begin
            ffv_nxt = 1'b1;
            ffi_nxt = idx;
          end
        end
        // Terminal compare happens before any increment, so idx never wraps.
        if (idx == IDX_LAST) begin
          state_nxt = S_DONE;
          pass_nxt  = (err_nxt == '0);
        end else begin
          state_nxt      = S_DRIVE;
          idx_nxt        = idx + IDX_ONE;
          settle_cnt_nxt = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // idx is zero in IDLE and holds the last vector in DONE, so it doubles as the stimulus.
  assign dut_in = idx;
  assign busy   = (state == S_DRIVE) || (state == S_CHECK);
  assign done   = (state == S_DONE);

endmodule
